// File: rtl/irq_router.sv
// Interrupt gateway: synchronises device IRQ lines, applies polarity, counts edge
// events with claim/complete gating and presents a pure level vector to the PLIC.
module irq_router #(
    parameter int NumSources = 4,
    parameter int NumIrqs    = 32,
    parameter int IdWidth    = $clog2(NumIrqs),
    // Squaring the "all entries = 1" vector yields entry i = i+1 (no carries while NumSources < 2**IdWidth)
    parameter logic [NumSources*IdWidth-1:0] SrcIrqMap =
        {NumSources{IdWidth'(1)}} * {NumSources{IdWidth'(1)}},
    parameter logic [NumSources-1:0] EdgeMask  = '0,
    parameter logic [NumSources-1:0] ActiveLow = '0,
    parameter int SyncStages = 2,
    parameter int CountWidth = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumSources-1:0] src_i,
    input  logic                  claim_valid_i,
    input  logic [IdWidth-1:0]    claim_id_i,
    input  logic                  complete_valid_i,
    input  logic [IdWidth-1:0]    complete_id_i,
    output logic [NumIrqs-1:0]    irq_o,
    output logic [NumIrqs-1:0]    edge_trigger_o,
    output logic [NumSources-1:0] overflow_o
);

    for (genvar g = 0; g < NumSources; g++) begin : g_map_chk
        if (int'(SrcIrqMap[g*IdWidth +: IdWidth]) == 0 ||
            int'(SrcIrqMap[g*IdWidth +: IdWidth]) >= NumIrqs) begin : g_bad_map
            $fatal(1, "irq_router: SrcIrqMap entry %0d is outside 1..NumIrqs-1", g);
        end
    end
    if (SyncStages < 1) begin : g_bad_sync
        $fatal(1, "irq_router: SyncStages must be at least 1");
    end

    function automatic logic [IdWidth-1:0] map_id(input int i);
        return SrcIrqMap[i*IdWidth +: IdWidth];
    endfunction

    // Saturating pending count; a simultaneous edge and claim cancel out.
    function automatic logic [CountWidth-1:0] cnt_next(input logic [CountWidth-1:0] c,
                                                       input logic inc, input logic dec);
        if (inc && !dec) return (c == '1) ? c : c + 1'b1;
        if (dec && !inc) return c - 1'b1;
        return c;
    endfunction

    logic [NumSources-1:0] sync_p [SyncStages];
    logic [NumSources-1:0] s;
    logic [NumSources-1:0] s_prev;
    logic [NumSources-1:0] in_service;
    logic [NumSources-1:0] ovf;
    logic [CountWidth-1:0] cnt [NumSources];
    logic [NumSources-1:0] edge_ev;
    logic [NumSources-1:0] hit;
    logic [NumSources-1:0] req;

    assign s = sync_p[SyncStages-1];

    always_comb begin
        edge_ev = EdgeMask & s & ~s_prev;
        hit     = '0;
        req     = '0;
        for (int i = 0; i < NumSources; i++) begin
            req[i] = (cnt[i] != '0) && !in_service[i];
            hit[i] = claim_valid_i && (claim_id_i == map_id(i)) && req[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < SyncStages; k++) sync_p[k] <= '0;
            for (int i = 0; i < NumSources; i++) cnt[i] <= '0;
            s_prev     <= '0;
            in_service <= '0;
            ovf        <= '0;
        end else begin
            // synchroniser stage boundary
            sync_p[0] <= src_i ^ ActiveLow;
            for (int k = 1; k < SyncStages; k++) sync_p[k] <= sync_p[k-1];
            s_prev <= s;
            for (int i = 0; i < NumSources; i++) begin
                cnt[i] <= cnt_next(cnt[i], edge_ev[i], hit[i]);
                if (edge_ev[i] && !hit[i] && (cnt[i] == '1)) ovf[i] <= 1'b1;
                if (hit[i]) begin
                    in_service[i] <= 1'b1;
                end else if (complete_valid_i && (complete_id_i == map_id(i))) begin
                    in_service[i] <= 1'b0;
                end
            end
        end
    end

    // Output is a pure OR of registered state, so inputs never reach outputs combinationally.
    always_comb begin
        irq_o = '0;
        for (int i = 0; i < NumSources; i++) begin
            if (EdgeMask[i] ? req[i] : s[i]) irq_o[map_id(i)] = 1'b1;
        end
        irq_o[0] = 1'b0;
    end

    assign edge_trigger_o = '0;
    assign overflow_o     = ovf;

endmodule
